alu_addseq: RTL and testbench

- Sequencer that performs multi-byte add/subtract by driving the shared 8-bit ALU adder one byte per clock, LSB first.
- Carry is propagated between bytes through an internal register.
- Sits between the core control unit (16-bit ops such as DAD/INX-style arithmetic) and the single 8-bit adder datapath, so no wide adder is needed.

---
 rtl/alu_addseq_if.sv | 46 ++++
 rtl/alu_addseq.sv | 152 +++++++++++++++
 tb/tb_alu_addseq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_addseq_if.sv
// Bus bundle for alu_addseq: core-side operation request/result plus the byte-slice adder link.
// Defining ALU_ADDSEQ_OVF_EN adds the signed-overflow result bit oOvf.
interface alu_addseq_if #(
   parameter int DATASIZE = 8,
   parameter int BYTES    = 2
);
   localparam int W = DATASIZE * BYTES;

   // iStart is a level request sampled only while the sequencer is idle; oDone
   // is a one-cycle pulse with oRes/oCout/oZero valid and held until the next start.
   logic                iStart;
   logic                iSub;
   logic                iCin;
   logic [W-1:0]        iOpA;
   logic [W-1:0]        iOpB;
   logic                oBusy;
   logic                oDone;
   logic [W-1:0]        oRes;
   logic                oCout;
   logic                oZero;
`ifdef ALU_ADDSEQ_OVF_EN
   logic                oOvf;
`endif
   logic [DATASIZE-1:0] oAluA;
   logic [DATASIZE-1:0] oAluB;
   logic                oAluC;
   logic [DATASIZE-1:0] iAluS;
   logic                iAluCo;
   logic [1:0]          dbg_state;

   modport slave (
`ifdef ALU_ADDSEQ_OVF_EN
      output oOvf,
`endif
      input  iStart, iSub, iCin, iOpA, iOpB, iAluS, iAluCo,
      output oBusy, oDone, oRes, oCout, oZero, oAluA, oAluB, oAluC, dbg_state
   );

   modport master (
`ifdef ALU_ADDSEQ_OVF_EN
      input  oOvf,
`endif
      output iStart, iSub, iCin, iOpA, iOpB, iAluS, iAluCo,
      input  oBusy, oDone, oRes, oCout, oZero, oAluA, oAluB, oAluC, dbg_state
   );
endinterface

// File: rtl/alu_addseq.sv
// Multi-byte add/subtract sequencer driving a shared DATASIZE-bit adder one slice per clock, LSB first.
// Optional signed-overflow output enabled by defining ALU_ADDSEQ_OVF_EN.
module alu_addseq #(
   parameter int DATASIZE = 8,
   parameter int BYTES    = 2
) (
   input logic         clk,
   input logic         rst_n,
   alu_addseq_if.slave bus
);
   localparam int W     = DATASIZE * BYTES;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        bx_q, bx_d;
   logic [W-1:0]        res_q, res_d;
   logic                sub_q, sub_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d;
   logic                zero_q, zero_d;
   logic [DATASIZE-1:0] alu_a, alu_b;
   logic                alu_c, busy, done;
`ifdef ALU_ADDSEQ_OVF_EN
   logic                ovf_q, ovf_d, cin_msb;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         bx_q    <= '0;
         res_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
`ifdef ALU_ADDSEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         res_q   <= res_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
`ifdef ALU_ADDSEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.iStart) state_d = S_RUN;
         S_RUN:   if (idx_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Adder slice outputs are forced to zero outside RUN so the shared adder sees a quiet bus.
   always_comb begin
      busy  = (state_q == S_RUN) || (state_q == S_DONE);
      done  = (state_q == S_DONE);
      alu_a = '0;
      alu_b = '0;
      alu_c = 1'b0;
      if (state_q == S_RUN) begin
         alu_c = carry_q;
         for (int i = 0; i < BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
               alu_a = a_q[i*DATASIZE +: DATASIZE];
               alu_b = bx_q[i*DATASIZE +: DATASIZE];
            end
         end
      end
   end

`ifdef ALU_ADDSEQ_OVF_EN
   assign cin_msb = bus.iAluS[DATASIZE-1] ^ alu_a[DATASIZE-1] ^ alu_b[DATASIZE-1];
`endif

   // Subtract is A + ~B + ~borrow, so B and the borrow-in are inverted once at capture.
   always_comb begin
      idx_d   = idx_q;
      a_d     = a_q;
      bx_d    = bx_q;
      res_d   = res_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
`ifdef ALU_ADDSEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               a_d     = bus.iOpA;
               bx_d    = bus.iOpB ^ {W{bus.iSub}};
               sub_d   = bus.iSub;
               carry_d = bus.iCin ^ bus.iSub;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            for (int i = 0; i < BYTES; i++) begin
               if (idx_q == IDX_W'(i)) res_d[i*DATASIZE +: DATASIZE] = bus.iAluS;
            end
            carry_d = bus.iAluCo;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               idx_d  = '0;
               cout_d = bus.iAluCo ^ sub_q;
               zero_d = (res_d == '0);
`ifdef ALU_ADDSEQ_OVF_EN
               ovf_d  = cin_msb ^ bus.iAluCo;
`endif
            end
         end
         default: ;
      endcase
   end

   assign bus.oBusy     = busy;
   assign bus.oDone     = done;
   assign bus.oRes      = res_q;
   assign bus.oCout     = cout_q;
   assign bus.oZero     = zero_q;
   assign bus.oAluA     = alu_a;
   assign bus.oAluB     = alu_b;
   assign bus.oAluC     = alu_c;
   assign bus.dbg_state = state_q;
`ifdef ALU_ADDSEQ_OVF_EN
   assign bus.oOvf      = ovf_q;
`endif
endmodule

// File: tb/tb_alu_addseq.sv
// Bench for alu_addseq: two instances (BYTES=2 and BYTES=1), each with an arithmetic adder model
// on its slice bus, checked by a scoreboard against a full-width reference model.
module tb_alu_addseq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // expected packing: [18]=ovf [17]=zero [16]=cout [15:0]=result
   logic [18:0] exp2_q[$];
   logic [18:0] exp1_q[$];

   alu_addseq_if #(.DATASIZE(8), .BYTES(2)) b2 ();
   alu_addseq_if #(.DATASIZE(8), .BYTES(1)) b1 ();

   alu_addseq #(.DATASIZE(8), .BYTES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   alu_addseq #(.DATASIZE(8), .BYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   // the shared 8-bit adder the sequencer drives
   assign {b2.iAluCo, b2.iAluS} = {1'b0, b2.oAluA} + {1'b0, b2.oAluB} + {8'b0, b2.oAluC};
   assign {b1.iAluCo, b1.iAluS} = {1'b0, b1.oAluA} + {1'b0, b1.oAluB} + {8'b0, b1.oAluC};

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [18:0] ref_model(input int w, input longint a, input longint b,
                                             input bit sub, input bit cin);
      longint m, r, sa, sb, sr;
      bit     co, ov;
      logic [15:0] r16;
      m  = longint'(1) << w;
      r  = sub ? (a - b - cin) : (a + b + cin);
      co = sub ? (r < 0) : (r >= m);
      r  = ((r % m) + m) % m;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      sr = sub ? (sa - sb - cin) : (sa + sb + cin);
      ov = (sr >= m / 2) || (sr < -(m / 2));
      r16 = r[15:0];
      return {ov, (r == 0), co, r16};
   endfunction

   // scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && b2.oDone) begin
         logic [18:0] e;
         if (exp2_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done2: got oDone=1 expected no completion");
         end else begin
            e = exp2_q.pop_front();
            check("res2", b2.oRes, e[15:0]);
            check("cout2", b2.oCout, e[16]);
            check("zero2", b2.oZero, e[17]);
`ifdef ALU_ADDSEQ_OVF_EN
            check("ovf2", b2.oOvf, e[18]);
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b1.oDone) begin
         logic [18:0] e;
         if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done1: got oDone=1 expected no completion");
         end else begin
            e = exp1_q.pop_front();
            check("res1", b1.oRes, e[7:0]);
            check("cout1", b1.oCout, e[16]);
            check("zero1", b1.oZero, e[17]);
`ifdef ALU_ADDSEQ_OVF_EN
            check("ovf1", b1.oOvf, e[18]);
`endif
         end
      end
   end

   task automatic op2(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
      int  k = 0;
      bit  seen = 0;
      bit  lo_carry;
      logic [15:0] bx;
      bx = b ^ {16{sub}};
      // low slice carries when the add overflows 8 bits, or the subtract needs no borrow
      lo_carry = sub ? !(int'(a[7:0]) < int'(b[7:0]) + int'(cin))
                     : (int'(a[7:0]) + int'(b[7:0]) + int'(cin) >= 256);
      @(negedge clk);
      b2.iOpA = a; b2.iOpB = b; b2.iSub = sub; b2.iCin = cin; b2.iStart = 1'b1;
      exp2_q.push_back(ref_model(16, longint'(a), longint'(b), sub, cin));
      repeat (10) begin
         @(negedge clk);
         b2.iStart = 1'b0;
         k++;
         if (k == 1) begin
            check("slice0_a", b2.oAluA, a[7:0]);
            check("slice0_b", b2.oAluB, bx[7:0]);
            check("slice0_c", b2.oAluC, cin ^ sub);
         end else if (k == 2) begin
            check("slice1_a", b2.oAluA, a[15:8]);
            check("slice1_c", b2.oAluC, lo_carry);
         end
         if (b2.oDone) begin
            seen = 1;
            break;
         end
      end
      check("latency2", k, seen ? 3 : 99);
      check("done_alu_quiet2", {b2.oAluA, b2.oAluB, b2.oAluC}, 17'h0);
      @(negedge clk);
      check("done_width2", b2.oDone, 1'b0);
      check("idle_busy2", b2.oBusy, 1'b0);
   endtask

   task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
      int k = 0;
      bit seen = 0;
      @(negedge clk);
      b1.iOpA = a; b1.iOpB = b; b1.iSub = sub; b1.iCin = cin; b1.iStart = 1'b1;
      exp1_q.push_back(ref_model(8, longint'(a), longint'(b), sub, cin));
      repeat (10) begin
         @(negedge clk);
         b1.iStart = 1'b0;
         k++;
         if (b1.oDone) begin
            seen = 1;
            break;
         end
      end
      check("latency1", k, seen ? 2 : 99);
   endtask

   initial begin
      b2.iStart = 0; b2.iSub = 0; b2.iCin = 0; b2.iOpA = '0; b2.iOpB = '0;
      b1.iStart = 0; b1.iSub = 0; b1.iCin = 0; b1.iOpA = '0; b1.iOpB = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", b2.oBusy, 1'b0);
      check("rst_done", b2.oDone, 1'b0);
      check("rst_res", b2.oRes, 16'h0);
      check("rst_flags", {b2.oCout, b2.oZero}, 2'b00);
      check("rst_alu", {b2.oAluA, b2.oAluB, b2.oAluC}, 17'h0);
      check("rst_res1", b1.oRes, 8'h0);
      rst_n = 1'b1;

      // directed cases
      op2(16'h1234, 16'h0FCD, 0, 0);
      op2(16'hFFFF, 16'h0001, 0, 0);
      op2(16'h1000, 16'h0001, 1, 0);
      op2(16'h0001, 16'h0002, 1, 0);
      op2(16'h0005, 16'h0003, 1, 1);
      op2(16'h7FFF, 16'h0001, 0, 0);
      op2(16'h8000, 16'h0001, 1, 0);
      op2(16'hFFFF, 16'hFFFF, 0, 1);
      op2(16'h0000, 16'h0000, 1, 1);

      // start re-asserted during RUN and DONE with different operands is ignored
      @(negedge clk);
      b2.iOpA = 16'h0100; b2.iOpB = 16'h0001; b2.iSub = 0; b2.iCin = 0; b2.iStart = 1'b1;
      exp2_q.push_back(ref_model(16, 64'h0100, 64'h0001, 0, 0));
      repeat (3) begin
         @(negedge clk);
         b2.iOpA = 16'hAAAA; b2.iOpB = 16'h5555; b2.iSub = 1;
      end
      check("ign_done_seen", b2.oDone, 1'b1);
      @(negedge clk);
      b2.iStart = 1'b0;
      check("ign_no_restart", b2.oBusy, 1'b0);
      repeat (3) @(negedge clk);
      check("ign_still_idle", b2.oBusy, 1'b0);

      // reset after the first RUN edge aborts with no completion
      @(negedge clk);
      b2.iOpA = 16'h1111; b2.iOpB = 16'h2222; b2.iSub = 0; b2.iCin = 0; b2.iStart = 1'b1;
      @(negedge clk);
      b2.iStart = 1'b0;
      @(negedge clk);
      check("pre_abort_busy", b2.oBusy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", b2.oBusy, 1'b0);
      check("abort_res", b2.oRes, 16'h0);
      check("abort_flags", {b2.oDone, b2.oCout, b2.oZero}, 3'b000);
      check("abort_alu", {b2.oAluA, b2.oAluB, b2.oAluC}, 17'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      op2(16'h1234, 16'h0FCD, 0, 0);

      // randomized operations
      repeat (300) op2(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // single-slice instance: corners then random slice pairs
      for (int s = 0; s < 4; s++) begin
         op1(8'h00, 8'h00, s[1], s[0]);
         op1(8'hFF, 8'hFF, s[1], s[0]);
         op1(8'hFF, 8'h01, s[1], s[0]);
         op1(8'h80, 8'h7F, s[1], s[0]);
         op1(8'h7F, 8'h80, s[1], s[0]);
      end
      repeat (1500) op1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (5) @(negedge clk);
      check("drain2", exp2_q.size(), 0);
      check("drain1", exp1_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
